// File: rtl/sample_dec_pkg.sv
// Shared types and decode helper for the registered sample decoder.
package sample_dec_pkg;

    typedef enum logic {DEC_ONEHOT, DEC_THERMO} dec_mode_t;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    // Raw decode of one output bit, before polarity; code is zero-extended by the caller.
    function automatic logic dec_bit(int unsigned idx, int unsigned code, dec_mode_t mode);
        if (mode == DEC_THERMO) begin
            return idx <= code;
        end
        return idx == code;
    endfunction

endpackage

// File: rtl/sample_skid.sv
// Generic 2-entry valid/ready skid register with a registered in_ready.
module sample_skid #(
    parameter int unsigned   W       = 1,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q;
    logic         skid_valid_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         load_main;

    // Main stage can take a new word when empty or when its current word leaves.
    assign load_main = !main_valid_q || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= RST_VAL;
            skid_q       <= RST_VAL;
        end else if (load_main) begin
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (in_valid) begin
                main_q       <= in_data;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (in_valid && !skid_valid_q) begin
            skid_q       <= in_data;
            skid_valid_q <= 1'b1;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_q;

endmodule

// File: rtl/sample_dec_pipe.sv
// Registered, handshaked binary decoder: combinational decode + polarity into a skid stage.
module sample_dec_pipe
    import sample_dec_pkg::*;
#(
    parameter int unsigned IN   = 4,
    parameter int unsigned OUT  = 1 << IN,
    parameter logic        ACT  = HIGH,
    parameter dec_mode_t   MODE = DEC_ONEHOT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IN-1:0]  in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OUT-1:0] out,
    output logic           out_err
);

    localparam logic ENABLE  = ACT;
    localparam logic DISABLE = ~ACT;
    localparam logic [OUT:0] RST_VAL = {1'b0, {OUT{DISABLE}}};

    logic [OUT-1:0] dec;
    logic           err;
    logic [OUT:0]   skid_out;

    always_comb begin
        dec = {OUT{DISABLE}};
        for (int unsigned i = 0; i < OUT; i++) begin
            dec[i] = dec_bit(i, 32'(in), MODE) ? ENABLE : DISABLE;
        end
    end

    assign err = 32'(in) >= OUT;

    sample_skid #(
        .W       (OUT + 1),
        .RST_VAL (RST_VAL)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({err, dec}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (skid_out)
    );

    assign {out_err, out} = skid_out;

endmodule

// File: tb/tb_sample_dec_pipe.sv
// Scoreboard bench: three decoder configurations share one handshake stream.
module tb_sample_dec_pipe;
    import sample_dec_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [3:0] in_code = 4'd0;

    logic in_ready_a, in_ready_b, in_ready_c;
    logic out_valid_a, out_valid_b, out_valid_c;
    logic out_err_a, out_err_b, out_err_c;
    logic [15:0] out_a;
    logic [9:0]  out_b, out_c;

    int n_vec = 0;
    int n_err = 0;
    int unsigned q[$];
    logic        stall_prev = 1'b0;
    logic [63:0] held_v;

    always #5 clk = ~clk;

    // a: 16-bit one-hot active-high, b: 10-bit thermometer active-high, c: 10-bit one-hot active-low
    sample_dec_pipe #(.IN(4), .OUT(16), .ACT(1'b1), .MODE(DEC_ONEHOT)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in(in_code),
        .out_valid(out_valid_a), .out_ready(out_ready), .out(out_a), .out_err(out_err_a));
    sample_dec_pipe #(.IN(4), .OUT(10), .ACT(1'b1), .MODE(DEC_THERMO)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in(in_code),
        .out_valid(out_valid_b), .out_ready(out_ready), .out(out_b), .out_err(out_err_b));
    sample_dec_pipe #(.IN(4), .OUT(10), .ACT(1'b0), .MODE(DEC_ONEHOT)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_c), .in(in_code),
        .out_valid(out_valid_c), .out_ready(out_ready), .out(out_c), .out_err(out_err_c));

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model(int unsigned code, int unsigned w, bit thermo,
                                          bit act_high);
        logic [15:0] mask, v;
        mask = 16'((32'd1 << w) - 32'd1);
        if (code >= w) v = thermo ? mask : 16'h0000;
        else v = thermo ? 16'((32'd2 << code) - 32'd1) : 16'(32'd1 << code);
        if (!act_high) v = ~v & mask;
        return v;
    endfunction

    function automatic logic [63:0] expect_out(int unsigned code);
        logic [15:0] va, vb, vc;
        logic [9:0]  sb, sc;
        va = model(code, 16, 1'b0, 1'b1);
        vb = model(code, 10, 1'b1, 1'b1);
        vc = model(code, 10, 1'b0, 1'b0);
        sb = vb[9:0];
        sc = vc[9:0];
        return 64'({1'b0, va, code >= 10, sb, code >= 10, sc, 2'b11});
    endfunction

    function automatic logic [63:0] actual_out();
        return 64'({out_err_a, out_a, out_err_b, out_b, out_err_c, out_c,
                    out_valid_b, out_valid_c});
    endfunction

    function automatic logic [63:0] actual_reset_state();
        return 64'({out_valid_a, out_valid_b, out_valid_c, in_ready_a, in_ready_b, in_ready_c,
                    out_err_a, out_err_b, out_err_c, out_a, out_b, out_c});
    endfunction

    localparam logic [63:0] RESET_STATE = 64'({3'b000, 3'b111, 3'b000, 16'h0000, 10'h000,
                                               10'h3FF});

    // Monitor: records accepted codes, checks every output transfer and stall stability.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_stable", {out_valid_a, actual_out()}, {1'b1, held_v});
            end
            if (in_valid && in_ready_a) q.push_back(32'(in_code));
            if (out_valid_a && out_ready) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_out: got output %h expected none at %0t",
                             actual_out(), $time);
                end else begin
                    int unsigned code;
                    code = q.pop_front();
                    check($sformatf("out_code%0d", code), actual_out(), expect_out(code));
                end
            end
            stall_prev <= out_valid_a && !out_ready;
            held_v     <= actual_out();
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned codes[4];
        int k;
        int sent;
        int cyc;
        logic acc;

        #1 reset = 1'b1;
        #2 check("reset_async", actual_reset_state(), RESET_STATE);
        repeat (2) cycle();
        check("reset_state", actual_reset_state(), RESET_STATE);
        reset = 1'b0;
        cycle();

        // Single code, one-cycle latency
        in_valid = 1'b1; in_code = 4'd5; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("latency", {out_valid_a, out_err_a, out_a}, {1'b1, 1'b0, 16'h0020});
        cycle();

        // Back-to-back, including out-of-range for the 10-bit decoders
        foreach (codes[i]) codes[i] = 0;
        codes[0] = 3; codes[1] = 0; codes[2] = 12; codes[3] = 9;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_code = 4'(codes[i]);
            cycle();
        end
        in_valid = 1'b0;
        repeat (3) cycle();

        // Backpressure: only two codes fit
        codes[0] = 1; codes[1] = 2; codes[2] = 3; codes[3] = 4;
        out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_code = 4'(codes[k]);
            acc = in_ready_a;
            cycle();
            if (acc) k++;
        end
        check("bp_accepted", 64'(k), 64'd2);
        check("bp_hold", {in_ready_a, out_valid_a, out_a}, {1'b0, 1'b1, 16'h0002});
        out_ready = 1'b1;
        cyc = 0;
        while (k < 4 && cyc < 20) begin
            in_code = 4'(codes[k]);
            acc = in_ready_a;
            cycle();
            if (acc) k++;
            cyc++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(k), 64'd4);
        repeat (4) cycle();
        check("bp_drained", 64'(q.size()), 64'd0);

        // Reset while the skid entry is full
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 4'd7;
        cycle();
        in_code = 4'd9;
        cycle();
        in_valid = 1'b0;
        check("skid_full", {in_ready_a, out_valid_a}, {1'b0, 1'b1});
        #2 reset = 1'b1;
        #1 check("reset_mid", actual_reset_state(), RESET_STATE);
        q.delete();
        cycle();
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (5) cycle();
        check("no_stale", {out_valid_a, in_ready_a}, {1'b0, 1'b1});

        // Random traffic
        sent = 0;
        cyc = 0;
        while (sent < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_code   = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 9) < 7);
            acc = in_valid && in_ready_a;
            cycle();
            if (acc) sent++;
            cyc++;
        end
        check("rand_sent", 64'(sent), 64'd10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            cycle();
            cyc++;
        end
        check("rand_drained", 64'(q.size()), 64'd0);
        repeat (2) cycle();
        check("final_idle", {out_valid_a, in_ready_a}, {1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
